proc_ctrl: RTL and testbench

PROC_CTRL -- requirements
Module: proc_ctrl

---
 rtl/proc_ctrl.sv | 137 +++++++++++++
 tb/tb_proc_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl.sv
// proc_ctrl: control unit for a simple bus-based processor.
// Fetches a 9-bit instruction (III XXX YYY) into IR on Run in T0, then steps through
// T1..T3 issuing bus/register control strobes. Supported: mv, mvi, add, sub; other
// opcodes complete as a nop. Counts completed instructions.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   run_i          start request, sampled only in T0
//   din_i[8:0]     instruction word in T0, immediate data in T1 of mvi
//   xaddr_o[2:0]   Rx field of IR (write-enable decoder select)
//   xwr_en_o       write-enable decoder enable
//   yaddr_o[2:0]   register selected to drive the bus (0 when yrd_en_o=0)
//   yrd_en_o       read-select decoder enable
//   dinout_o       DIN drives the bus
//   ain_o          load A from bus
//   gin_o          load G from ALU
//   gout_o         G drives the bus
//   addsub_o       ALU op: 0 add, 1 subtract
//   done_o         instruction completes this cycle
//   instr_count_o  completed-instruction count, modulo 256
module proc_ctrl (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       run_i,
   input  logic [8:0] din_i,
   output logic [2:0] xaddr_o,
   output logic       xwr_en_o,
   output logic [2:0] yaddr_o,
   output logic       yrd_en_o,
   output logic       dinout_o,
   output logic       ain_o,
   output logic       gin_o,
   output logic       gout_o,
   output logic       addsub_o,
   output logic       done_o,
   output logic [7:0] instr_count_o
);

   typedef enum logic [1:0] {
      StT0 = 2'd0,
      StT1 = 2'd1,
      StT2 = 2'd2,
      StT3 = 2'd3
   } state_e;

   localparam logic [2:0] OpMv  = 3'b000;
   localparam logic [2:0] OpMvi = 3'b001;
   localparam logic [2:0] OpAdd = 3'b010;
   localparam logic [2:0] OpSub = 3'b011;

   state_e     state_q;
   logic [8:0] ir_q;
   logic [7:0] count_q;

   logic [2:0] opcode;
   logic       is_arith;

   assign opcode   = ir_q[8:6];
   // add and sub share opcode[2:1] = 01; opcode[0] selects subtract
   assign is_arith = (ir_q[8:7] == 2'b01);

   // Moore decode: outputs depend only on state_q and ir_q
   always_comb begin
      xaddr_o  = ir_q[5:3];
      xwr_en_o = 1'b0;
      yaddr_o  = 3'd0;
      yrd_en_o = 1'b0;
      dinout_o = 1'b0;
      ain_o    = 1'b0;
      gin_o    = 1'b0;
      gout_o   = 1'b0;
      addsub_o = 1'b0;
      done_o   = 1'b0;
      unique case (state_q)
         StT0: ;
         StT1: begin
            unique case (opcode)
               OpMv: begin
                  yrd_en_o = 1'b1;
                  yaddr_o  = ir_q[2:0];
                  xwr_en_o = 1'b1;
                  done_o   = 1'b1;
               end
               OpMvi: begin
                  dinout_o = 1'b1;
                  xwr_en_o = 1'b1;
                  done_o   = 1'b1;
               end
               OpAdd, OpSub: begin
                  yrd_en_o = 1'b1;
                  yaddr_o  = ir_q[5:3];
                  ain_o    = 1'b1;
               end
               default: done_o = 1'b1;
            endcase
         end
         StT2: begin
            yrd_en_o = 1'b1;
            yaddr_o  = ir_q[2:0];
            gin_o    = 1'b1;
            addsub_o = ir_q[6];
         end
         StT3: begin
            gout_o   = 1'b1;
            xwr_en_o = 1'b1;
            done_o   = 1'b1;
         end
      endcase
   end

   assign instr_count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StT0;
         ir_q    <= 9'd0;
         count_q <= 8'd0;
      end else begin
         if (done_o) begin
            count_q <= count_q + 8'd1;
         end
         unique case (state_q)
            StT0: begin
               if (run_i) begin
                  ir_q    <= din_i;
                  state_q <= StT1;
               end
            end
            StT1: state_q <= is_arith ? StT2 : StT0;
            StT2: state_q <= StT3;
            StT3: state_q <= StT0;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_ctrl.sv
module tb_proc_ctrl;

   logic       clk;
   logic       rst;
   logic       run;
   logic [8:0] din;
   logic [2:0] xaddr;
   logic       xwr_en;
   logic [2:0] yaddr;
   logic       yrd_en;
   logic       dinout;
   logic       ain;
   logic       gin;
   logic       gout;
   logic       addsub;
   logic       done;
   logic [7:0] instr_count;

   proc_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .run_i         (run),
      .din_i         (din),
      .xaddr_o       (xaddr),
      .xwr_en_o      (xwr_en),
      .yaddr_o       (yaddr),
      .yrd_en_o      (yrd_en),
      .dinout_o      (dinout),
      .ain_o         (ain),
      .gin_o         (gin),
      .gout_o        (gout),
      .addsub_o      (addsub),
      .done_o        (done),
      .instr_count_o (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [13:0] v;
      logic [7:0]  cnt;
   } exp_t;

   exp_t       q[$];
   exp_t       cur;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_count = 8'd0;

   logic [13:0] act;
   logic        active;
   assign act    = {xaddr, xwr_en, yaddr, yrd_en, dinout, ain, gin, gout, addsub, done};
   assign active = xwr_en | yrd_en | dinout | ain | gin | gout | done;

   function automatic logic [13:0] ov(input logic [2:0] xa, input bit xw, input logic [2:0] ya,
                                      input bit yr, input bit di, input bit ai, input bit gi,
                                      input bit go, input bit as, input bit dn);
      return {xa, xw, ya, yr, di, ai, gi, go, as, dn};
   endfunction

   // Monitor: every cycle with control activity is matched against the next expectation
   always @(negedge clk) begin
      if (active) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got outputs=%b count=%0d, required none queued",
                     act, instr_count);
         end else begin
            cur = q.pop_front();
            if (act !== cur.v || instr_count !== cur.cnt) begin
               errors++;
               $display("FAIL %s: got outputs=%b count=%0d, required outputs=%b count=%0d",
                        cur.name, act, instr_count, cur.v, cur.cnt);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string n, input logic [13:0] v, input bit inc);
      exp_t e;
      e.name = n;
      e.v    = v;
      e.cnt  = exp_count;
      q.push_back(e);
      if (inc) exp_count = exp_count + 8'd1;
   endtask

   // T0 check: no strobes, Xaddr tracks IR, count matches the model
   task automatic check_idle(input string n, input logic [2:0] xa);
      checks++;
      if (act !== {xa, 11'b0} || instr_count !== exp_count) begin
         errors++;
         $display("FAIL %s: got outputs=%b count=%0d, required outputs=%b count=%0d",
                  n, act, instr_count, {xa, 11'b0}, exp_count);
      end
   endtask

   task automatic fetch(input logic [8:0] d);
      din = d;
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      run = 1'b0;
      din = 9'd0;
      repeat (2) tick();
      rst = 1'b0;
      check_idle("reset", 3'd0);

      // Reset during T2 of add: T1/T2 strobes seen, then clean T0, count untouched
      push("rstT2_t1", ov(3, 0, 3, 1, 0, 1, 0, 0, 0, 0), 0);
      push("rstT2_t2", ov(3, 0, 1, 1, 0, 0, 1, 0, 0, 0), 0);
      fetch(9'b010_011_001);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_in_t2", 3'd0);

      // Reset during T3: Done still visible that cycle, but no count increment
      push("rstT3_t1", ov(1, 0, 1, 1, 0, 1, 0, 0, 0, 0), 0);
      push("rstT3_t2", ov(1, 0, 2, 1, 0, 0, 1, 0, 0, 0), 0);
      push("rstT3_t3", ov(1, 1, 0, 0, 0, 0, 0, 1, 0, 1), 0);
      fetch(9'b010_001_010);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_in_t3", 3'd0);

      // mv R3,R5
      push("mv_t1", ov(3, 1, 5, 1, 0, 0, 0, 0, 0, 1), 1);
      fetch(9'b000_011_101);
      tick();
      check_idle("mv_t0_count", 3'd3);

      // mvi R2,#0x55
      push("mvi_t1", ov(2, 1, 0, 0, 1, 0, 0, 0, 0, 1), 1);
      fetch(9'b001_010_000);
      din = 9'h055;
      tick();
      check_idle("mvi_t0", 3'd2);

      // sub R1,R6
      push("sub_t1", ov(1, 0, 1, 1, 0, 1, 0, 0, 0, 0), 0);
      push("sub_t2", ov(1, 0, 6, 1, 0, 0, 1, 0, 1, 0), 0);
      push("sub_t3", ov(1, 1, 0, 0, 0, 0, 0, 1, 0, 1), 1);
      fetch(9'b011_001_110);
      repeat (3) tick();
      check_idle("sub_t0", 3'd1);

      // add R4,R2 with Run/DIN toggling in T1..T3
      push("add_t1", ov(4, 0, 4, 1, 0, 1, 0, 0, 0, 0), 0);
      push("add_t2", ov(4, 0, 2, 1, 0, 0, 1, 0, 0, 0), 0);
      push("add_t3", ov(4, 1, 0, 0, 0, 0, 0, 1, 0, 1), 1);
      fetch(9'b010_100_010);
      run = 1'b1;
      din = 9'h1FF;
      tick();
      run = 1'b0;
      din = 9'b000_111_111;
      tick();
      run = 1'b1;
      tick();
      run = 1'b0;
      check_idle("add_ir_hold", 3'd4);

      // Back-to-back with Run held high: mv R5,R3 then nop
      push("b2b_mv", ov(5, 1, 3, 1, 0, 0, 0, 0, 0, 1), 1);
      push("b2b_nop", ov(6, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1);
      din = 9'b000_101_011;
      run = 1'b1;
      tick();
      din = 9'b100_110_000;
      tick();
      tick();
      run = 1'b0;
      tick();
      check_idle("b2b_t0", 3'd6);

      // Reset, then 256 undefined-opcode instructions wrap the count to 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_count = 8'd0;
      check_idle("reset2", 3'd0);
      for (int i = 0; i < 256; i++) begin
         push("nop", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1);
         fetch(9'b110_000_000);
         tick();
      end
      check_idle("nop_wrap", 3'd0);

      repeat (2) tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending, required 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
